fir_frame_buffer: RTL and testbench

//   Sink for the FIR output stream (fir_valid/fir_d). Packs consecutive filtered samples into

---
 rtl/fir_pkg.sv | 22 ++
 rtl/frame_bank.sv | 44 ++++
 rtl/fir_frame_buffer.sv | 143 ++++++++++++++
 tb/tb_fir_frame_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fir_pkg
// Description : Shared sizing constants and sample type for the FIR output
//               frame buffer (fir_frame_buffer and its frame_bank storage).
//               DATA_W    - sample width (signed two's complement)
//               FRAME_LEN - samples per frame, power of 2 in 2..64
//               IDX_W     - width of a sample index within a frame
//               DROP_W    - width of the saturating dropped-sample counter
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 16;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int DROP_W    = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank
// Description : One FRAME_LEN x DATA_W register bank. A single write port
//               stores wdata at index widx when we is high. The whole bank is
//               visible at once on rdata, so a full frame can be presented in
//               parallel.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset, clears all words
//   we     in   write enable
//   widx   in   IDX_W       word index to write
//   wdata  in   DATA_W      sample to write
//   rdata  out  FRAME_LEN*DATA_W  rdata[k*DATA_W +: DATA_W] = word k
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank
    import fir_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            widx,
    input  sample_t                     wdata,
    output logic [FRAME_LEN*DATA_W-1:0] rdata
);

    // Each word lives in its own generate scope so every register has
    // exactly one driving process.
    for (genvar k = 0; k < FRAME_LEN; k++) begin : g_word
        sample_t r_word;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_word <= '0;
            end else if (we && (widx == IDX_W'(k))) begin
                r_word <= wdata;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = r_word;
    end : g_word

endmodule : frame_bank
`default_nettype wire

// File: rtl/fir_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_frame_buffer
// Description : Packs the FIR output stream into FRAME_LEN-sample frames held
//               in two ping-pong banks and presents each full frame in
//               parallel with a valid/ready handshake. Samples arriving while
//               the write bank is still occupied are dropped and counted.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   fir_valid    in   one sample per cycle while high
//   fir_d        in   DATA_W       FIR sample
//   frame_valid  out  a full frame is presented
//   frame_ready  in   downstream accepts the presented frame
//   frame_data   out  FRAME_LEN*DATA_W  sample k at [k*DATA_W +: DATA_W], k=0 oldest
//   frame_bank   out  bank index of the presented frame
//   ovf_clr      in   synchronous clear of overflow and drop_cnt
//   overflow     out  sticky, at least one sample dropped
//   drop_cnt     out  DROP_W       dropped samples, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_buffer
    import fir_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fir_valid,
    input  logic [DATA_W-1:0]           fir_d,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [FRAME_LEN*DATA_W-1:0] frame_data,
    output logic                        frame_bank,
    input  logic                        ovf_clr,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_cnt
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]        r_bank_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_wr_full;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_last;
    logic              w_accept;
    logic [1:0]        w_we;
    logic [1:0]        w_bank_full_nxt;
    logic [FRAME_LEN*DATA_W-1:0] w_rdata [2];

    // Fullness of the write bank is taken from registered state only, so a
    // bank released by an accept this cycle is writable from the next cycle.
    assign w_wr_full = r_bank_full[r_wr_bank];
    assign w_wr_en   = fir_valid & ~w_wr_full;
    assign w_drop    = fir_valid &  w_wr_full;
    assign w_last    = (r_wr_idx == c_last_idx);
    assign w_accept  = frame_valid & frame_ready;

    assign w_we[0]   = w_wr_en & ~r_wr_bank;
    assign w_we[1]   = w_wr_en &  r_wr_bank;

    // An accept and a frame completion can only hit different banks: the
    // accept needs its bank full, the write needs its bank empty.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_accept) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_en && w_last) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_bank_full <= w_bank_full_nxt;

            if (w_wr_en) begin
                if (w_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + IDX_W'(1);
                end
            end

            if (w_accept) begin
                r_rd_bank <= ~r_rd_bank;
            end

            // A clear takes priority over a coincident drop.
            if (ovf_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: two identical banks sharing the write index and data
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (w_we[b]),
            .widx  (r_wr_idx),
            .wdata (fir_d),
            .rdata (w_rdata[b])
        );
    end : g_bank

    // ------------------------------------------------------------------
    // Read side: straight from registered state, so data is stable for as
    // long as the frame waits for acceptance.
    // ------------------------------------------------------------------
    assign frame_valid = r_bank_full[r_rd_bank];
    assign frame_data  = r_rd_bank ? w_rdata[1] : w_rdata[0];
    assign frame_bank  = r_rd_bank;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule : fir_frame_buffer
`default_nettype wire

// File: tb/tb_fir_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_frame_buffer
// Description : Self-checking bench for fir_frame_buffer. A frame-queue model
//               (up to two completed frames plus one partial frame) predicts
//               every output; directed scenarios and a random run compare the
//               DUT against it and against hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_buffer;
    import fir_pkg::*;

    localparam int FLAT     = FRAME_LEN * DATA_W;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                fir_valid = 1'b0;
    logic [DATA_W-1:0]   fir_d = '0;
    logic                frame_valid;
    logic                frame_ready = 1'b0;
    logic [FLAT-1:0]     frame_data;
    logic                frame_bank;
    logic                ovf_clr = 1'b0;
    logic                overflow;
    logic [DROP_W-1:0]   drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of completed frames, partial frame being built
    logic [FLAT-1:0] m_frames [$];
    logic [FLAT-1:0] m_part;
    int              m_cnt;
    logic            m_rd_tag;
    logic            m_ovf;
    int              m_drop;

    always #5 clk = ~clk;

    fir_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .fir_valid   (fir_valid),
        .fir_d       (fir_d),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_bank  (frame_bank),
        .ovf_clr     (ovf_clr),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    task automatic model_reset();
        m_frames.delete();
        m_part   = '0;
        m_cnt    = 0;
        m_rd_tag = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    // Drive one cycle of inputs, advance the model over the clock edge and
    // return 1 time unit after the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic rdy, input logic clr);
        int f;
        fir_valid   = v;
        fir_d       = d;
        frame_ready = rdy;
        ovf_clr     = clr;
        @(posedge clk);
        f = m_frames.size();
        if (f > 0 && rdy) begin
            void'(m_frames.pop_front());
            m_rd_tag = ~m_rd_tag;
        end
        if (v) begin
            if (f == 2) begin
                m_ovf = 1'b1;
                if (m_drop < DROP_MAX) m_drop++;
            end else begin
                m_part[m_cnt*DATA_W +: DATA_W] = d;
                m_cnt++;
                if (m_cnt == FRAME_LEN) begin
                    m_frames.push_back(m_part);
                    m_part = '0;
                    m_cnt  = 0;
                end
            end
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        fir_valid = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0; fir_d = '0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        fir_valid = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_checks++; if (frame_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", frame_data); end
        n_checks++; if (frame_bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank: got %b want 0", frame_bank); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // 16 samples 1..16 with ready held high: a one-cycle frame
    task automatic test_single_frame();
        logic [FLAT-1:0] exp_data;
        do_reset();
        for (int k = 0; k < FRAME_LEN; k++) begin
            exp_data[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
            if (k == FRAME_LEN - 1) begin
                n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", frame_valid); end
            end
            step(1'b1, DATA_W'(k + 1), 1'b1, 1'b0);
        end
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", frame_valid); end
        n_checks++; if (frame_data !== exp_data) begin n_fail++; $display("FAIL single_data: got %h want %h", frame_data, exp_data); end
        n_checks++; if (frame_bank !== 1'b0) begin n_fail++; $display("FAIL single_bank: got %b want 0", frame_bank); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", frame_valid); end
        n_checks++; if (frame_bank !== 1'b1) begin n_fail++; $display("FAIL single_bank_toggle: got %b want 1", frame_bank); end
    endtask

    // 48 samples with no ready: two frames held, 16 dropped; saturation; clear
    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 48; k++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", frame_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++; if (drop_cnt !== DROP_W'(16)) begin n_fail++; $display("FAIL ovf_drop16: got %0d want 16", drop_cnt); end
        n_checks++; if (frame_data !== m_frames[0]) begin n_fail++; $display("FAIL ovf_data: got %h want %h", frame_data, m_frames[0]); end
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_flag: got %b want 0", overflow); end
        n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL ovf_clr_cnt: got %0d want 0", drop_cnt); end
        for (int k = 0; k < DROP_MAX + 20; k++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        n_checks++; if (drop_cnt !== DROP_W'(DROP_MAX)) begin n_fail++; $display("FAIL ovf_saturate: got %0d want %0d", drop_cnt, DROP_MAX); end
        step(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        n_checks++; if (drop_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_wins: got cnt=%0d ovf=%b want 0/0", drop_cnt, overflow); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", frame_valid); end
    endtask

    // Held frame stays stable while a second fills; both leave in order
    task automatic test_stall();
        logic [FLAT-1:0] frame_a, frame_b;
        do_reset();
        for (int k = 0; k < FRAME_LEN; k++) begin
            frame_a[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            step(1'b1, frame_a[k*DATA_W +: DATA_W], 1'b0, 1'b0);
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            frame_b[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            step(1'b1, frame_b[k*DATA_W +: DATA_W], 1'b0, 1'b0);
            n_checks++;
            if (frame_data !== frame_a || frame_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h/%b want %h/1", k, frame_data, frame_valid, frame_a);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (frame_valid !== 1'b1 || frame_bank !== 1'b1) begin n_fail++; $display("FAIL stall_second: got v=%b bank=%b want 1/1", frame_valid, frame_bank); end
        n_checks++; if (frame_data !== frame_b) begin n_fail++; $display("FAIL stall_second_data: got %h want %h", frame_data, frame_b); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (frame_valid !== 1'b0 || frame_bank !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got v=%b bank=%b want 0/0", frame_valid, frame_bank); end
    endtask

    // Alternating valid: 16 samples over 32 cycles form exactly one frame
    task automatic test_gaps();
        logic [FLAT-1:0] exp_data;
        do_reset();
        for (int c = 0; c < 2 * FRAME_LEN; c++) begin
            if (c % 2 == 0) begin
                exp_data[(c/2)*DATA_W +: DATA_W] = DATA_W'($urandom);
                step(1'b1, exp_data[(c/2)*DATA_W +: DATA_W], 1'b0, 1'b0);
            end else begin
                step(1'b0, DATA_W'($urandom), 1'b0, 1'b0);
            end
            if (c == 2 * FRAME_LEN - 3) begin
                n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early: got %b want 0", frame_valid); end
            end
        end
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", frame_valid); end
        n_checks++; if (frame_data !== exp_data) begin n_fail++; $display("FAIL gaps_data: got %h want %h", frame_data, exp_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL gaps_ovf: got %b want 0", overflow); end
    endtask

    // Asynchronous reset in the middle of a frame discards everything
    task automatic test_reset_mid();
        logic [FLAT-1:0] exp_data;
        do_reset();
        for (int k = 0; k < FRAME_LEN + 7; k++) step(1'b1, DATA_W'($urandom | 1), 1'b0, 1'b0);
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", frame_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (frame_valid !== 1'b0 || frame_data !== '0) begin n_fail++; $display("FAIL rmid_async: got v=%b data=%h want 0/0", frame_valid, frame_data); end
        fir_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            exp_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            step(1'b1, exp_data[k*DATA_W +: DATA_W], 1'b0, 1'b0);
        end
        n_checks++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got v=%b bank=%b want 1/0", frame_valid, frame_bank); end
        n_checks++; if (frame_data !== exp_data) begin n_fail++; $display("FAIL rmid_data: got %h want %h", frame_data, exp_data); end
    endtask

    // Bank 0 accepted in the cycle the 33rd sample targets it
    task automatic test_accept_collision();
        logic [FLAT-1:0] exp_b0;
        do_reset();
        for (int k = 0; k < 2 * FRAME_LEN; k++) step(1'b1, DATA_W'(k + 1), 1'b0, 1'b0);
        step(1'b1, DATA_W'(33), 1'b1, 1'b0);
        n_checks++; if (drop_cnt !== DROP_W'(1)) begin n_fail++; $display("FAIL coll_drop: got %0d want 1", drop_cnt); end
        n_checks++; if (frame_bank !== 1'b1 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL coll_bank: got bank=%b v=%b want 1/1", frame_bank, frame_valid); end
        exp_b0[0 +: DATA_W] = 16'h8000;
        step(1'b1, 16'h8000, 1'b0, 1'b0);
        for (int k = 1; k < FRAME_LEN; k++) begin
            exp_b0[k*DATA_W +: DATA_W] = DATA_W'(34 + k);
            step(1'b1, DATA_W'(34 + k), 1'b0, 1'b0);
        end
        n_checks++; if (drop_cnt !== DROP_W'(1)) begin n_fail++; $display("FAIL coll_no_more_drop: got %0d want 1", drop_cnt); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (frame_bank !== 1'b0 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL coll_b0_bank: got bank=%b v=%b want 0/1", frame_bank, frame_valid); end
        n_checks++; if (frame_data !== exp_b0) begin n_fail++; $display("FAIL coll_b0_data: got %h want %h", frame_data, exp_b0); end
    endtask

    // Random traffic against the frame-queue model
    task automatic test_random();
        logic v, r, c;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 49) == 0);
            step(v, DATA_W'($urandom), r, c);
            n_checks++;
            if (frame_valid !== (m_frames.size() > 0) || frame_bank !== m_rd_tag ||
                overflow !== m_ovf || drop_cnt !== DROP_W'(m_drop)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got v=%b bank=%b ovf=%b drop=%0d want v=%b bank=%b ovf=%b drop=%0d",
                         i, frame_valid, frame_bank, overflow, drop_cnt,
                         m_frames.size() > 0, m_rd_tag, m_ovf, m_drop);
            end
            if (m_frames.size() > 0) begin
                n_checks++;
                if (frame_data !== m_frames[0]) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, frame_data, m_frames[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_stall();
        test_gaps();
        test_reset_mid();
        test_accept_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fir_frame_buffer
`default_nettype wire
